// File: rtl/cacheline_arbiter_pkg.sv
// Shared types and constants for the cacheline arbiter between the I-cache,
// the D-cache and the single physical-memory port.
package cacheline_arbiter_pkg;

  localparam int unsigned LINE_WIDTH  = 256;
  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned OFFSET_BITS = 5;
  localparam int unsigned WD_WIDTH    = 16;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } mem_op_t;

  // Transaction captured at grant; drives the memory port for the whole serve.
  typedef struct packed {
    mem_op_t                 op;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [LINE_WIDTH-1:0]   data;
  } mem_req_t;

  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
    return {addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_arbiter_if.sv
// Bundle of cache request/response and physical-memory signals. The arbiter
// uses the slave view; the surrounding caches and memory use the master view.
interface cacheline_arbiter_if;
  import cacheline_arbiter_pkg::*;

  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic                  i_resp;
  logic [LINE_WIDTH-1:0] i_rdata;

  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic                  d_resp;
  logic [LINE_WIDTH-1:0] d_rdata;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic                  pmem_resp;
  logic [LINE_WIDTH-1:0] pmem_rdata;

  logic                  timeout;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_resp, pmem_rdata,
    output i_resp, i_rdata, d_resp, d_rdata,
           pmem_read, pmem_write, pmem_address, pmem_wdata, timeout
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_resp, pmem_rdata,
    input  i_resp, i_rdata, d_resp, d_rdata,
           pmem_read, pmem_write, pmem_address, pmem_wdata, timeout
  );

endinterface

// File: rtl/cacheline_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last
// time is granted. Grant is one-hot {D, I} and purely combinational.
module rr_arbiter2
  import cacheline_arbiter_pkg::*;
(
  input  logic       req_icache_i,
  input  logic       req_dcache_i,
  input  grant_t     last_grant_i,
  output logic [1:0] grant_c_o
);

  always_comb begin
    grant_c_o = 2'b00;
    if (req_icache_i && req_dcache_i) begin
      grant_c_o = (last_grant_i == GRANT_D) ? 2'b01 : 2'b10;
    end else if (req_icache_i) begin
      grant_c_o = 2'b01;
    end else if (req_dcache_i) begin
      grant_c_o = 2'b10;
    end
  end

endmodule

// File: rtl/cacheline_arbiter.sv
// Shares one cacheline memory port between the I-cache and D-cache: one
// transaction at a time, round-robin on ties, sticky watchdog on hung memory.
module cacheline_arbiter
  import cacheline_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  cacheline_arbiter_if.slave arb
);

  localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_WIDTH-1:0] WD_MAX   = {WD_WIDTH{1'b1}};

  arb_state_t          state_q, state_d;
  grant_t              last_grant_q, last_grant_d;
  mem_req_t            req_q, req_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [WD_WIDTH-1:0] wd_q, wd_d;
  logic                timeout_q, timeout_d;
  logic [1:0]          grant_c;
  logic                i_resp_c, d_resp_c;

  rr_arbiter2 u_rr (
    .req_icache_i (arb.i_read),
    .req_dcache_i (arb.d_read | arb.d_write),
    .last_grant_i (last_grant_q),
    .grant_c_o    (grant_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      req_q        <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      wd_q         <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      req_q        <= req_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      wd_q         <= wd_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    req_d        = req_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    wd_d         = wd_q;
    timeout_d    = timeout_q;
    i_resp_c     = 1'b0;
    d_resp_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_c[0]) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
          req_d.op     = OP_READ;
          req_d.addr   = line_align(arb.i_address);
          rd_d         = 1'b1;
          wr_d         = 1'b0;
          wd_d         = '0;
        end else if (grant_c[1]) begin
          // A write-back wins over a simultaneous (illegal) read request.
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
          req_d.op     = arb.d_write ? OP_WRITE : OP_READ;
          req_d.addr   = line_align(arb.d_address);
          req_d.data   = arb.d_wdata;
          rd_d         = ~arb.d_write;
          wr_d         = arb.d_write;
          wd_d         = '0;
        end
      end

      SERVE_I, SERVE_D: begin
        if (arb.pmem_resp) begin
          i_resp_c = (state_q == SERVE_I);
          d_resp_c = (state_q == SERVE_D);
          state_d  = IDLE;
          rd_d     = 1'b0;
          wr_d     = 1'b0;
        end else begin
          rd_d = (req_q.op == OP_READ);
          wr_d = (req_q.op == OP_WRITE);
          if (wd_q >= WD_LIMIT) begin
            timeout_d = 1'b1;
          end
          if (wd_q != WD_MAX) begin
            wd_d = wd_q + WD_WIDTH'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  assign arb.pmem_read    = rd_q;
  assign arb.pmem_write   = wr_q;
  assign arb.pmem_address = req_q.addr;
  assign arb.pmem_wdata   = req_q.data;
  assign arb.timeout      = timeout_q;
  assign arb.i_resp       = i_resp_c;
  assign arb.d_resp       = d_resp_c;
  assign arb.i_rdata      = arb.pmem_rdata;
  assign arb.d_rdata      = arb.pmem_rdata;

  // Protocol violations by the caches or memory; simulation-only checks.
  a_no_dread_dwrite: assert property (@(posedge clk) disable iff (rst)
    !(arb.d_read && arb.d_write));
  a_no_resp_in_idle: assert property (@(posedge clk) disable iff (rst)
    !((state_q == IDLE) && arb.pmem_resp));

endmodule
